// File: rtl/track_sequencer.sv
// Per-frame tracking scheduler: template capture, one-frame static buffer fill,
// correlation with timeout, and publication of the accepted match position.
module track_sequencer #(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FRAME_SKIP     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tracking_mode,
  input  logic        frame_end,
  input  logic        template_rdy,
  input  logic        max_ready,
  input  logic [9:0]  max_x,
  input  logic [9:0]  max_y,
  output logic        template_start,
  output logic        static_we_en,
  output logic        corr_start,
  output logic [9:0]  track_x,
  output logic [9:0]  track_y,
  output logic        track_valid,
  output logic        timeout_err,
  output logic [15:0] frames_tracked
);

  localparam int TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SK_W_RAW = $clog2(FRAME_SKIP + 1);
  localparam int SK_W     = (SK_W_RAW < 1) ? 1 : SK_W_RAW;

  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SK_W-1:0] SK_TARGET = SK_W'(FRAME_SKIP);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_TEMPLATE  = 3'd1;
  localparam logic [2:0] S_ARM       = 3'd2;
  localparam logic [2:0] S_FILL      = 3'd3;
  localparam logic [2:0] S_CORRELATE = 3'd4;
  localparam logic [2:0] S_UPDATE    = 3'd5;
  localparam logic [2:0] S_SKIP      = 3'd6;

  logic [2:0]      state_q,  state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [SK_W-1:0] skip_q,   skip_d;
  logic            ts_q,     ts_d;
  logic            we_q,     we_d;
  logic            cs_q,     cs_d;
  logic            tv_q,     tv_d;
  logic            err_q,    err_d;
  logic [9:0]      tx_q,     tx_d;
  logic [9:0]      ty_q,     ty_d;
  logic [15:0]     frames_q, frames_d;
  logic [SK_W-1:0] skip_inc;

  assign skip_inc = skip_q + SK_W'(1);

  // Next-state and next-output logic; leaving tracking mode overrides everything.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    skip_d   = skip_q;
    ts_d     = 1'b0;
    cs_d     = 1'b0;
    tv_d     = 1'b0;
    we_d     = we_q;
    err_d    = err_q;
    tx_d     = tx_q;
    ty_d     = ty_q;
    frames_d = frames_q;

    if (!tracking_mode) begin
      state_d = S_IDLE;
      we_d    = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_TEMPLATE;
          ts_d    = 1'b1;
          we_d    = 1'b0;
        end
        S_TEMPLATE: begin
          if (template_rdy) begin
            state_d = S_ARM;
          end else begin
            state_d = S_TEMPLATE;
          end
        end
        S_ARM: begin
          if (frame_end) begin
            state_d = S_FILL;
            we_d    = 1'b1;
          end else begin
            we_d    = 1'b0;
          end
        end
        S_FILL: begin
          if (frame_end) begin
            state_d  = S_CORRELATE;
            we_d     = 1'b0;
            cs_d     = 1'b1;
            to_cnt_d = '0;
          end else begin
            we_d     = 1'b1;
          end
        end
        S_CORRELATE: begin
          // A result on the expiry cycle still counts as a success.
          if (max_ready) begin
            state_d = S_UPDATE;
          end else if (to_cnt_q == TO_LAST) begin
            state_d = S_ARM;
            err_d   = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        S_UPDATE: begin
          tx_d     = max_x;
          ty_d     = max_y;
          tv_d     = 1'b1;
          frames_d = (frames_q == 16'hFFFF) ? frames_q : frames_q + 16'd1;
          if (FRAME_SKIP == 0) begin
            state_d = S_ARM;
          end else begin
            state_d = S_SKIP;
            skip_d  = '0;
          end
        end
        S_SKIP: begin
          if (frame_end) begin
            if (skip_inc == SK_TARGET) begin
              state_d = S_ARM;
            end else begin
              skip_d  = skip_inc;
            end
          end else begin
            skip_d = skip_q;
          end
        end
        default: begin
          state_d = S_IDLE;
          we_d    = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      to_cnt_q <= '0;
      skip_q   <= '0;
      ts_q     <= 1'b0;
      we_q     <= 1'b0;
      cs_q     <= 1'b0;
      tv_q     <= 1'b0;
      err_q    <= 1'b0;
      tx_q     <= 10'd0;
      ty_q     <= 10'd0;
      frames_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      skip_q   <= skip_d;
      ts_q     <= ts_d;
      we_q     <= we_d;
      cs_q     <= cs_d;
      tv_q     <= tv_d;
      err_q    <= err_d;
      tx_q     <= tx_d;
      ty_q     <= ty_d;
      frames_q <= frames_d;
    end
  end

  assign template_start = ts_q;
  assign static_we_en   = we_q;
  assign corr_start     = cs_q;
  assign track_valid    = tv_q;
  assign timeout_err    = err_q;
  assign track_x        = tx_q;
  assign track_y        = ty_q;
  assign frames_tracked = frames_q;

endmodule
